serial_add_ctrl: RTL

Bit-serial adder sequencer for the RCA datapath. It reuses a single full-adder bit slice (in0, in1, cin -> sum, cout) over WIDTH clock cycles to add two WIDTH-bit operands plus carry-in, LSB first. Carry is registered between cycles. It is the area-minimal alternative to the parallel ripple-carry adder and exposes a start/busy/done handshake to the surrounding control logic.

---
 rtl/serial_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Bit-serial adder sequencer. A single full-adder slice is reused over WIDTH
// cycles, LSB first, to compute {cout, sum} = a + b + cin.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   start_i  operation request (accepted in IDLE, and in DONE for back-to-back)
//   a_i      operand A, captured on accept
//   b_i      operand B, captured on accept
//   cin_i    carry-in, captured on accept
//   busy_o   high in RUN and DONE
//   done_o   one-cycle pulse, result valid
//   sum_o    result register
//   cout_o   final carry-out register
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one bit-step per cycle, cnt_q = bit index being processed
// DONE  | result valid on sum_o/cout_o; start here begins the next operation
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;

   logic             slice_sum, slice_cout;
   logic             last_bit, accept;

   // Full-adder slice on the shift-register LSBs.
   assign slice_sum  = a_q[0] ^ b_q[0] ^ carry_q;
   assign slice_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

   assign last_bit = (state_q == S_RUN) && (cnt_q == CW'(WIDTH - 1));

   // Accepting in DONE as well as IDLE lets a held start run back-to-back
   // with no idle gap, giving one operation per WIDTH+1 cycles.
   assign accept = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Partial result shifts right with the new bit entering at the MSB.
   always_comb begin
      res_d            = res_q >> 1;
      res_d[WIDTH-1]   = slice_sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_i) state_d = S_RUN;
         S_RUN:   if (last_bit) state_d = S_DONE;
         S_DONE:  state_d = start_i ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == S_RUN) || (state_q == S_DONE);
      done_o = (state_q == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= a_i;
         b_q     <= b_i;
         carry_q <= cin_i;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         res_q   <= res_d;
         carry_q <= slice_cout;
         cnt_q   <= cnt_q + CW'(1);
         // Result registers load on entry to DONE so they are valid while
         // done_o is high; otherwise they hold the previous result.
         if (last_bit) begin
            sum_q  <= res_d;
            cout_q <= slice_cout;
         end
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule
